// File: rtl/wash_timer_sensor_if.sv
// FSM-facing bundle for wash_timer_sensor: timer enables and raw level in, conditioned flags out.
// The pause signal exists only when WASH_TIMER_PAUSE_EN is defined.
interface wash_timer_sensor_if;
   logic       motor_on;
   logic       spin_run;
`ifdef WASH_TIMER_PAUSE_EN
   logic       pause;
`endif
   logic [7:0] level_raw;
   logic       cycle_timeout;
   logic       spin_timeout;
   logic       filled;
   logic       drained;

`ifdef WASH_TIMER_PAUSE_EN
   modport master (output motor_on, spin_run, pause, level_raw,
                   input  cycle_timeout, spin_timeout, filled, drained);
   modport slave  (input  motor_on, spin_run, pause, level_raw,
                   output cycle_timeout, spin_timeout, filled, drained);
`else
   modport master (output motor_on, spin_run, level_raw,
                   input  cycle_timeout, spin_timeout, filled, drained);
   modport slave  (input  motor_on, spin_run, level_raw,
                   output cycle_timeout, spin_timeout, filled, drained);
`endif
endinterface

// File: rtl/wash_timer_sensor.sv
// Phase timers (cycle/spin timeouts) and debounced fill/drain sensing for the wash FSM; WASH_TIMER_PAUSE_EN adds a timer pause.
// Latency: timeouts after TICKS*PRESCALE enabled edges, level flags after DEBOUNCE samples; no backpressure, outputs registered.
module wash_timer_sensor #(
   parameter int         PRESCALE    = 1000,
   parameter int         CYCLE_TICKS = 600,
   parameter int         SPIN_TICKS  = 300,
   parameter logic [7:0] FULL_LEVEL  = 8'd200,
   parameter logic [7:0] EMPTY_LEVEL = 8'd10,
   parameter int         DEBOUNCE    = 16
) (
   input logic                clk,
   input logic                reset,
   wash_timer_sensor_if.slave bus
);

   localparam int PW = $clog2(PRESCALE) + 1;
   localparam int CW = $clog2(CYCLE_TICKS) + 1;
   localparam int SW = $clog2(SPIN_TICKS) + 1;
   localparam int DW = $clog2(DEBOUNCE) + 1;

   logic [PW-1:0] cyc_presc, spin_presc;
   logic [CW-1:0] cyc_ticks;
   logic [SW-1:0] spin_ticks;
   logic          cyc_to, spin_to;
   logic [DW-1:0] fill_cnt, drain_cnt;
   logic          filled_q, drained_q;
   logic          full_c, empty_c, hold;

`ifdef WASH_TIMER_PAUSE_EN
   assign hold = bus.pause;
`else
   assign hold = 1'b0;
`endif

   assign full_c  = (bus.level_raw >= FULL_LEVEL);
   assign empty_c = (bus.level_raw <= EMPTY_LEVEL);

   // Once the timeout is set the whole timer freezes until its enable drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_presc <= '0;
         cyc_ticks <= '0;
         cyc_to    <= 1'b0;
      end else if (!bus.motor_on) begin
         cyc_presc <= '0;
         cyc_ticks <= '0;
         cyc_to    <= 1'b0;
      end else if (!cyc_to && !hold) begin
         if (cyc_presc == PW'(PRESCALE - 1)) begin
            cyc_presc <= '0;
            cyc_ticks <= cyc_ticks + CW'(1);
            if (cyc_ticks == CW'(CYCLE_TICKS - 1))
               cyc_to <= 1'b1;
         end else begin
            cyc_presc <= cyc_presc + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spin_presc <= '0;
         spin_ticks <= '0;
         spin_to    <= 1'b0;
      end else if (!bus.spin_run) begin
         spin_presc <= '0;
         spin_ticks <= '0;
         spin_to    <= 1'b0;
      end else if (!spin_to && !hold) begin
         if (spin_presc == PW'(PRESCALE - 1)) begin
            spin_presc <= '0;
            spin_ticks <= spin_ticks + SW'(1);
            if (spin_ticks == SW'(SPIN_TICKS - 1))
               spin_to <= 1'b1;
         end else begin
            spin_presc <= spin_presc + PW'(1);
         end
      end
   end

   // Each flag flips only after DEBOUNCE consecutive samples disagreeing with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt  <= '0;
         filled_q  <= 1'b0;
         drain_cnt <= '0;
         drained_q <= 1'b0;
      end else begin
         if (full_c == filled_q) begin
            fill_cnt <= '0;
         end else if (fill_cnt == DW'(DEBOUNCE - 1)) begin
            filled_q <= full_c;
            fill_cnt <= '0;
         end else begin
            fill_cnt <= fill_cnt + DW'(1);
         end

         if (empty_c == drained_q) begin
            drain_cnt <= '0;
         end else if (drain_cnt == DW'(DEBOUNCE - 1)) begin
            drained_q <= empty_c;
            drain_cnt <= '0;
         end else begin
            drain_cnt <= drain_cnt + DW'(1);
         end
      end
   end

   assign bus.cycle_timeout = cyc_to;
   assign bus.spin_timeout  = spin_to;
   assign bus.filled        = filled_q;
   assign bus.drained       = drained_q;

endmodule

// File: tb/tb_wash_timer_sensor.sv
// Bench for wash_timer_sensor: directed scenarios then random traffic against a run-length reference model.
`timescale 1ns/1ps
module tb_wash_timer_sensor;
   localparam int P   = 4;
   localparam int CT  = 5;
   localparam int ST  = 3;
   localparam int DB  = 4;
   localparam int FUL = 200;
   localparam int EMP = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wash_timer_sensor_if bus ();

   wash_timer_sensor #(
      .PRESCALE(P), .CYCLE_TICKS(CT), .SPIN_TICKS(ST),
      .FULL_LEVEL(8'd200), .EMPTY_LEVEL(8'd10), .DEBOUNCE(DB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model: timers are lengths of unbroken enabled (unpaused) runs;
   // level flags follow the run length of identical condition samples since reset.
   int   cyc_len, spin_len;
   int   lrun [2];
   logic lval [2];
   logic lout [2];

   task automatic model_reset();
      cyc_len = 0;
      spin_len = 0;
      for (int k = 0; k < 2; k++) begin
         lrun[k] = 0;
         lval[k] = 1'b0;
         lout[k] = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".cycle_timeout"}, bus.cycle_timeout, cyc_len >= CT * P);
      check({tag, ".spin_timeout"},  bus.spin_timeout,  spin_len >= ST * P);
      check({tag, ".filled"},        bus.filled,        lout[0]);
      check({tag, ".drained"},       bus.drained,       lout[1]);
   endtask

   task automatic step(input string tag);
      logic m, s, p;
      logic c [2];
      m = bus.motor_on;
      s = bus.spin_run;
`ifdef WASH_TIMER_PAUSE_EN
      p = bus.pause;
`else
      p = 1'b0;
`endif
      c[0] = (int'(bus.level_raw) >= FUL);
      c[1] = (int'(bus.level_raw) <= EMP);
      @(posedge clk);
      if (!m) cyc_len = 0; else if (!p) cyc_len++;
      if (!s) spin_len = 0; else if (!p) spin_len++;
      for (int k = 0; k < 2; k++) begin
         if (lrun[k] == 0 || c[k] != lval[k]) begin
            lval[k] = c[k];
            lrun[k] = 1;
         end else begin
            lrun[k]++;
         end
         if (lrun[k] >= DB && lval[k] != lout[k]) lout[k] = lval[k];
      end
      #1;
      check_all(tag);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset = 1'b1;
      #1;
      check({tag, ".async_cycle"},  bus.cycle_timeout, 1'b0);
      check({tag, ".async_spin"},   bus.spin_timeout,  1'b0);
      check({tag, ".async_filled"}, bus.filled,        1'b0);
      check({tag, ".async_drain"},  bus.drained,       1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1;
      bus.motor_on = 1'b0;
      bus.spin_run = 1'b0;
      bus.level_raw = 8'd100;
`ifdef WASH_TIMER_PAUSE_EN
      bus.pause = 1'b0;
`endif
      model_reset();
      #12;
      check("rst.cycle_timeout", bus.cycle_timeout, 1'b0);
      check("rst.spin_timeout",  bus.spin_timeout,  1'b0);
      check("rst.filled",        bus.filled,        1'b0);
      check("rst.drained",       bus.drained,       1'b0);
      reset = 1'b0;

      // cycle timer: rises on the 20th enabled edge, holds, clears on drop
      bus.motor_on = 1'b1;
      for (int i = 1; i <= 19; i++) step("cyc");
      check("cyc.edge19", bus.cycle_timeout, 1'b0);
      step("cyc");
      check("cyc.edge20", bus.cycle_timeout, 1'b1);
      for (int i = 0; i < 5; i++) step("cyc_hold");
      check("cyc.held", bus.cycle_timeout, 1'b1);
      bus.motor_on = 1'b0;
      step("cyc_drop");
      check("cyc.dropped", bus.cycle_timeout, 1'b0);

      // spin timer restart: 7 on, 1 off, then 12 more edges
      bus.spin_run = 1'b1;
      for (int i = 0; i < 7; i++) step("spin_a");
      bus.spin_run = 1'b0;
      step("spin_gap");
      bus.spin_run = 1'b1;
      for (int i = 1; i <= 11; i++) step("spin_b");
      check("spin.edge11", bus.spin_timeout, 1'b0);
      step("spin_b");
      check("spin.edge12", bus.spin_timeout, 1'b1);
      bus.spin_run = 1'b0;
      step("spin_drop");

      // both timers from the same edge
      bus.motor_on = 1'b1;
      bus.spin_run = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step("both");
         if (i == 11) check("both.spin11", bus.spin_timeout, 1'b0);
         if (i == 12) check("both.spin12", bus.spin_timeout, 1'b1);
         if (i == 19) check("both.cyc19", bus.cycle_timeout, 1'b0);
         if (i == 20) check("both.cyc20", bus.cycle_timeout, 1'b1);
      end
      bus.motor_on = 1'b0;
      bus.spin_run = 1'b0;
      step("both_drop");

      // filled debounce with an interrupted run
      bus.level_raw = 8'd205;
      for (int i = 0; i < 3; i++) step("fill_a");
      bus.level_raw = 8'd150;
      step("fill_glitch");
      bus.level_raw = 8'd205;
      for (int i = 0; i < 3; i++) step("fill_b");
      check("fill.sample3", bus.filled, 1'b0);
      step("fill_b");
      check("fill.sample4", bus.filled, 1'b1);
      bus.level_raw = 8'd100;
      for (int i = 0; i < 3; i++) step("fill_c");
      check("fill.fall3", bus.filled, 1'b1);
      step("fill_c");
      check("fill.fall4", bus.filled, 1'b0);
      check("fill.drained_low", bus.drained, 1'b0);

      // drained at the exact threshold, then asynchronous reset mid-run
      bus.level_raw = 8'd10;
      bus.motor_on = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step("drain");
         if (i == 3) check("drain.sample3", bus.drained, 1'b0);
         if (i == 4) check("drain.sample4", bus.drained, 1'b1);
      end
      for (int i = 0; i < 20; i++) step("drain_run");
      check("drain.cyc_up", bus.cycle_timeout, 1'b1);
      async_reset_pulse("mid");
      for (int i = 1; i <= 4; i++) begin
         step("post_rst");
         if (i == 3) check("post_rst.drain3", bus.drained, 1'b0);
         if (i == 4) check("post_rst.drain4", bus.drained, 1'b1);
      end
      bus.motor_on = 1'b0;
      step("post_rst");

`ifdef WASH_TIMER_PAUSE_EN
      // pause for 6 edges delays the timeout from edge 20 to 26
      bus.motor_on = 1'b1;
      for (int i = 1; i <= 26; i++) begin
         bus.pause = (i >= 9 && i <= 14);
         step("pause");
         if (i == 25) check("pause.edge25", bus.cycle_timeout, 1'b0);
         if (i == 26) check("pause.edge26", bus.cycle_timeout, 1'b1);
      end
      bus.pause = 1'b1;
      bus.motor_on = 1'b0;
      step("pause_clear");
      check("pause.clear", bus.cycle_timeout, 1'b0);
      bus.pause = 1'b0;
`endif

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) bus.motor_on = ~bus.motor_on;
         if ($urandom_range(0, 14) == 0) bus.spin_run = ~bus.spin_run;
`ifdef WASH_TIMER_PAUSE_EN
         if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
`endif
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0: bus.level_raw = 8'($urandom_range(0, 10));
               1: bus.level_raw = 8'($urandom_range(11, 199));
               2: bus.level_raw = 8'($urandom_range(200, 255));
               default: begin
                  case ($urandom_range(0, 3))
                     0: bus.level_raw = 8'd10;
                     1: bus.level_raw = 8'd11;
                     2: bus.level_raw = 8'd199;
                     default: bus.level_raw = 8'd200;
                  endcase
               end
            endcase
         end
         if ($urandom_range(0, 499) == 0) async_reset_pulse("rnd_rst");
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
